gt_rx_block_lock: RTL
=====================

# gt_rx_block_lock

Per-lane 64b/66b receive-side block aligner for the GTYP PRBS path: consumes the two sync headers delivered per rxusrclk cycle by the GT RX gearbox, drives the gearbox slip request until header alignment is found, and tracks lock using a sliding bad-header window. It sits between one GT channel's RX gearbox outputs and the PRBS checker, forwarding RX data only while block lock is held. It is the receiving counterpart of the TX header/sequence generation.

## Interface
Parameters:
- LOCK_CNT, 64: consecutive valid headers required to declare lock
- WINDOW, 64: headers per bad-header monitoring window while locked
- BAD_MAX, 16: bad headers within one window that force lock loss
- SLIP_WAIT, 32: rxusrclk cycles headers are ignored after each slip pulse

Ports:
- rxusrclk  in  1  lane RX user clock; all logic on this clock
- rst  in  1  reset, asynchronous, active-high
- lock_en  in  1  0 holds FSM in HUNT with counters cleared
- rxheader  in  6  header k in bits [3k+1:3k], k=0,1; bits 2 and 5 ignored
- rxheadervalid  in  2  bit k qualifies header k
- rxdata  in  128  word k in bits [64k+63:64k]
- rxdatavalid  in  2  bit k qualifies data word k
- rxgearboxslip  out  1  one-cycle slip request to the GT
- block_lock  out  1  high while in LOCKED
- rx_data_out  out  128  registered rxdata
- rx_data_valid_out  out  2  registered rxdatavalid AND block_lock
- stats_clr  in  1  synchronous clear of statistics
- slip_count  out  16  slips issued, saturating
- lock_loss_count  out  16  LOCKED exits, saturating
- bad_hdr_count  out  32  bad headers seen in LOCKED, saturating

## Operation
- Header valid (good) when value is 2'b01 or 2'b10; 2'b00/2'b11 bad. Unqualified headers are neither counted nor checked.
- Up to two headers per cycle; n_good, n_bad ∈ {0,1,2}.
- HUNT: good_cnt += n_good; any bad → SLIP, good_cnt cleared; else good_cnt+n_good ≥ LOCK_CNT → LOCKED, win_cnt and bad_cnt cleared. A bad header in the same cycle as reaching LOCK_CNT wins (→ SLIP).
- SLIP: rxgearboxslip=1 for exactly one cycle, timer loaded SLIP_WAIT → WAIT.
- WAIT: headers ignored; timer decrements; at 0 → HUNT with good_cnt=0.
- LOCKED: win_cnt += n_good+n_bad; bad_cnt += n_bad. bad_cnt+n_bad ≥ BAD_MAX → SLIP (checked first). Else win_cnt+n ≥ WINDOW → both cleared (carry-over discarded).
- lock_en low in any state → HUNT, counters cleared, no slip; an in-progress slip pulse is not extended.
- Counter widths: $clog2(max param)+1, no wrap possible.

## Timing
- Reset values: rxgearboxslip 0, block_lock 0, rx_data_out 0, rx_data_valid_out 0, all stats 0; FSM in HUNT.
- Header in cycle N decides state in N+1; rxgearboxslip and block_lock are registered state decodes, visible in N+1.
- Slip pulse spacing is SLIP_WAIT+1 cycles minimum (one SLIP plus SLIP_WAIT WAIT cycles).
- Data path latency 1 cycle; rx_data_valid_out uses block_lock of the same output cycle.
- Reset mid-slip drops rxgearboxslip immediately (async).
- stats_clr has priority over same-cycle increments.

## Configuration
- GT_RX_LOCK_STATS_EN defined: slip_count, lock_loss_count, bad_hdr_count implemented as saturating counters cleared by stats_clr.
- Not defined: counters removed; the three outputs tied to 0, stats_clr ignored. Lock behaviour identical.

## Structure
- Package gt_rx_lock_pkg: state enum (HUNT, SLIP, WAIT, LOCKED), header constants SH_DATA=2'b01, SH_CTRL=2'b10, header field width 2 and stride 3.
- Sub-module gt_rx_hdr_check: combinational per-cycle header classifier producing n_good/n_bad from rxheader/rxheadervalid.

## Test plan
- 64 good headers (32 cycles, both valid): block_lock rises in cycle after 32nd, no slips; rx_data_valid_out follows rxdatavalid next cycle.
- Header 2'b11 on k=1 during HUNT: rxgearboxslip high exactly 1 cycle, then 32 cycles ignored, then HUNT; slip_count=1.
- LOCKED, 15 bad in window of 64: lock held, counters reset; 16 bad in window: SLIP next cycle, lock_loss_count=1.
- Cycle where good_cnt reaches 64 with second header bad: enters SLIP, block_lock stays 0.
- rst asserted during slip pulse and during LOCKED: all outputs 0 immediately, HUNT after release; lock_en low forces block_lock 0 next cycle.
- Without GT_RX_LOCK_STATS_EN, repeat slip test: stats outputs stay 0; with it, stats_clr mid-run zeros counters and 0xFFFF saturates.

Source files
------------

// File: rtl/gt_rx_lock_pkg.sv
// gt_rx_lock_pkg: shared state encoding, sync-header constants and counter sizing for the RX block aligner.
package gt_rx_lock_pkg;
    typedef enum logic [1:0] {HUNT, SLIP, WAIT, LOCKED} lock_state_e;

    localparam logic [1:0] SH_DATA    = 2'b01;
    localparam logic [1:0] SH_CTRL    = 2'b10;
    localparam int         HDR_W      = 2;
    localparam int         HDR_STRIDE = 3;
    localparam int         HDR_LANES  = 2;

    function automatic logic hdr_good(input logic [HDR_W-1:0] h);
        return h == SH_DATA || h == SH_CTRL;
    endfunction

    // One spare bit above the largest threshold so count+2 never wraps.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        m = m > d ? m : d;
        return $clog2(m) + 1;
    endfunction
endpackage

// File: rtl/gt_rx_hdr_check.sv
// gt_rx_hdr_check: combinational classifier counting good and bad qualified sync headers in one rxusrclk cycle.
module gt_rx_hdr_check
    import gt_rx_lock_pkg::*;
(
    input  logic [5:0] rxheader,
    input  logic [1:0] rxheadervalid,
    output logic [1:0] n_good,
    output logic [1:0] n_bad
);
    logic [HDR_LANES-1:0] good;
    logic [HDR_LANES-1:0] bad;
    logic                 unused_hdr_bits;

    assign unused_hdr_bits = ^{rxheader[5], rxheader[2]};

    always_comb begin
        good = '0;
        bad  = '0;
        for (int k = 0; k < HDR_LANES; k++) begin
            good[k] = rxheadervalid[k] && hdr_good(rxheader[HDR_STRIDE*k +: HDR_W]);
            bad[k]  = rxheadervalid[k] && !hdr_good(rxheader[HDR_STRIDE*k +: HDR_W]);
        end
        n_good = {1'b0, good[0]} + {1'b0, good[1]};
        n_bad  = {1'b0, bad[0]} + {1'b0, bad[1]};
    end
endmodule

// File: rtl/gt_rx_block_lock.sv
// gt_rx_block_lock: 64b/66b RX block aligner driving gearbox slip and tracking lock with a bad-header window.
// Optional statistics counters are built when GT_RX_LOCK_STATS_EN is defined.
module gt_rx_block_lock
    import gt_rx_lock_pkg::*;
#(
    parameter int LOCK_CNT  = 64,
    parameter int WINDOW    = 64,
    parameter int BAD_MAX   = 16,
    parameter int SLIP_WAIT = 32
) (
    input  logic         rxusrclk,
    input  logic         rst,
    input  logic         lock_en,
    input  logic [5:0]   rxheader,
    input  logic [1:0]   rxheadervalid,
    input  logic [127:0] rxdata,
    input  logic [1:0]   rxdatavalid,
    output logic         rxgearboxslip,
    output logic         block_lock,
    output logic [127:0] rx_data_out,
    output logic [1:0]   rx_data_valid_out,
    input  logic         stats_clr,
    output logic [15:0]  slip_count,
    output logic [15:0]  lock_loss_count,
    output logic [31:0]  bad_hdr_count
);
    localparam int CW = cnt_width(LOCK_CNT, WINDOW, BAD_MAX, SLIP_WAIT);

    lock_state_e   state, state_n;
    logic [CW-1:0] good_cnt, good_cnt_n, win_cnt, win_cnt_n, bad_cnt, bad_cnt_n, timer, timer_n;
    logic [CW-1:0] good_sum, win_sum, bad_sum;
    logic [1:0]    n_good, n_bad;
    logic [1:0]    dv_q;

    gt_rx_hdr_check u_hdr (
        .rxheader      (rxheader),
        .rxheadervalid (rxheadervalid),
        .n_good        (n_good),
        .n_bad         (n_bad)
    );

    assign good_sum = good_cnt + CW'(n_good);
    assign win_sum  = win_cnt + CW'(n_good) + CW'(n_bad);
    assign bad_sum  = bad_cnt + CW'(n_bad);

    always_ff @(posedge rxusrclk or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            good_cnt <= '0;
            win_cnt  <= '0;
            bad_cnt  <= '0;
            timer    <= '0;
        end else begin
            state    <= state_n;
            good_cnt <= good_cnt_n;
            win_cnt  <= win_cnt_n;
            bad_cnt  <= bad_cnt_n;
            timer    <= timer_n;
        end
    end

    always_comb begin
        state_n    = state;
        good_cnt_n = good_cnt;
        win_cnt_n  = win_cnt;
        bad_cnt_n  = bad_cnt;
        timer_n    = timer;
        if (!lock_en) begin
            state_n    = HUNT;
            good_cnt_n = '0;
            win_cnt_n  = '0;
            bad_cnt_n  = '0;
            timer_n    = '0;
        end else begin
            case (state)
                HUNT: begin
                    // A bad header outranks reaching the lock threshold in the same cycle.
                    if (n_bad != 2'd0) begin
                        state_n    = SLIP;
                        good_cnt_n = '0;
                    end else if (good_sum >= CW'(LOCK_CNT)) begin
                        state_n    = LOCKED;
                        good_cnt_n = '0;
                        win_cnt_n  = '0;
                        bad_cnt_n  = '0;
                    end else begin
                        good_cnt_n = good_sum;
                    end
                end
                SLIP: begin
                    state_n = WAIT;
                    timer_n = CW'(SLIP_WAIT);
                end
                WAIT: begin
                    if (timer <= CW'(1)) begin
                        state_n    = HUNT;
                        good_cnt_n = '0;
                        timer_n    = '0;
                    end else begin
                        timer_n = timer - CW'(1);
                    end
                end
                LOCKED: begin
                    if (bad_sum >= CW'(BAD_MAX)) begin
                        state_n = SLIP;
                    end else if (win_sum >= CW'(WINDOW)) begin
                        win_cnt_n = '0;
                        bad_cnt_n = '0;
                    end else begin
                        win_cnt_n = win_sum;
                        bad_cnt_n = bad_sum;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    assign rxgearboxslip     = state == SLIP;
    assign block_lock        = state == LOCKED;
    assign rx_data_valid_out = dv_q & {2{block_lock}};

    always_ff @(posedge rxusrclk or posedge rst) begin
        if (rst) begin
            rx_data_out <= '0;
            dv_q        <= '0;
        end else begin
            rx_data_out <= rxdata;
            dv_q        <= rxdatavalid;
        end
    end

`ifdef GT_RX_LOCK_STATS_EN
    logic [32:0] bad_hdr_sum;

    assign bad_hdr_sum = {1'b0, bad_hdr_count} + 33'((state == LOCKED && lock_en) ? n_bad : 2'd0);

    always_ff @(posedge rxusrclk or posedge rst) begin
        if (rst) begin
            slip_count      <= '0;
            lock_loss_count <= '0;
            bad_hdr_count   <= '0;
        end else if (stats_clr) begin
            slip_count      <= '0;
            lock_loss_count <= '0;
            bad_hdr_count   <= '0;
        end else begin
            if (state_n == SLIP && slip_count != '1)
                slip_count <= slip_count + 16'd1;
            if (state == LOCKED && state_n != LOCKED && lock_loss_count != '1)
                lock_loss_count <= lock_loss_count + 16'd1;
            bad_hdr_count <= bad_hdr_sum[32] ? '1 : bad_hdr_sum[31:0];
        end
    end
`else
    logic unused_stats_clr;

    assign unused_stats_clr = stats_clr;
    assign slip_count       = '0;
    assign lock_loss_count  = '0;
    assign bad_hdr_count    = '0;
`endif
endmodule
